// File: rtl/data_mem_sync.sv
// Single-port data memory with registered read, valid/ready request handshake
// and a zeroing sweep that runs after every reset before requests are accepted.
module data_mem_sync #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 2 ** ADDR_W
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [DATA_W-1:0] data_in,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] data_out,
  output logic              err_out,
  output logic              init_done
);

  localparam int unsigned PTR_W = ADDR_W + 1;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    CLEAR,
    READY
  } state_e;

  state_e              state_q, state_d;
  logic [PTR_W-1:0]    clr_ptr_q, clr_ptr_d;
  logic                ready_q, ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic                err_q, err_d;
  logic [DATA_W-1:0]   data_out_q, data_out_d;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic                mem_we;
  logic [IDX_W-1:0]    mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic                accept;
  logic                in_range;

  // ready_q only ever rises in READY, so it doubles as the acceptance qualifier
  assign accept   = req_valid & ready_q;
  assign in_range = {1'b0, addr_in} < PTR_W'(DEPTH);

  // State, pointer and output registers
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      err_q       <= 1'b0;
      data_out_q  <= '0;
    end else begin
      state_q     <= state_d;
      clr_ptr_q   <= clr_ptr_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      err_q       <= err_d;
      data_out_q  <= data_out_d;
    end
  end

  // Next-state, memory write port and response generation
  always_comb begin
    state_d     = state_q;
    clr_ptr_d   = clr_ptr_q;
    rsp_valid_d = 1'b0;
    err_d       = 1'b0;
    data_out_d  = data_out_q;
    mem_we      = 1'b0;
    mem_waddr   = '0;
    mem_wdata   = '0;

    case (state_q)
      CLEAR: begin
        mem_we    = 1'b1;
        mem_waddr = clr_ptr_q[IDX_W-1:0];
        clr_ptr_d = clr_ptr_q + PTR_W'(1);
        if (clr_ptr_q == PTR_W'(DEPTH - 1)) begin
          state_d = READY;
        end
      end
      READY: begin
        if (accept) begin
          if (in_range) begin
            if (req_write) begin
              mem_we    = 1'b1;
              mem_waddr = addr_in[IDX_W-1:0];
              mem_wdata = data_in;
            end else begin
              rsp_valid_d = 1'b1;
              data_out_d  = mem[addr_in[IDX_W-1:0]];
            end
          end else begin
            // Out-of-range writes are dropped; reads answer zero
            err_d = 1'b1;
            if (!req_write) begin
              rsp_valid_d = 1'b1;
              data_out_d  = '0;
            end
          end
        end
      end
      default: begin
        state_d = CLEAR;
      end
    endcase

    ready_d = (state_d == READY);
  end

  // Storage array; reset blocks any write on the same edge
  always_ff @(posedge CLK) begin
    if (!RESET && mem_we) begin
      mem[mem_waddr] <= mem_wdata;
    end
  end

  assign req_ready = ready_q;
  assign init_done = ready_q;
  assign rsp_valid = rsp_valid_q;
  assign data_out  = data_out_q;
  assign err_out   = err_q;

endmodule

// File: tb/tb_data_mem_sync.sv
// Randomised self-checking bench for data_mem_sync (DEPTH=16, ADDR_W=8) against
// a behavioural memory model, plus directed cases with literal expectations.
module tb_data_mem_sync;

  localparam int unsigned DW = 8;
  localparam int unsigned AW = 8;
  localparam int unsigned DP = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [AW-1:0] addr_in = '0;
  logic [DW-1:0] data_in = '0;
  logic          rsp_valid;
  logic [DW-1:0] data_out;
  logic          err_out;
  logic          init_done;

  data_mem_sync #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DP)) dut (
    .CLK       (clk),
    .RESET     (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_write (req_write),
    .addr_in   (addr_in),
    .data_in   (data_in),
    .rsp_valid (rsp_valid),
    .data_out  (data_out),
    .err_out   (err_out),
    .init_done (init_done)
  );

  always #5 clk = ~clk;

  // Reference model: contents, remaining sweep writes, expected outputs
  logic [DW-1:0] mm [DP];
  int            sweep_left = DP;
  logic          e_rsp = 1'b0;
  logic          e_err = 1'b0;
  logic          e_rdy = 1'b0;
  logic [DW-1:0] e_data = '0;
  bit            chk_en = 1'b0;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // One clock: drive inputs, advance the model on the edge, return at negedge
  task automatic cycle(input logic r, input logic v, input logic w,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    bit was_ready;
    rst = r; req_valid = v; req_write = w; addr_in = a; data_in = d;
    @(posedge clk);
    was_ready = (sweep_left == 0);
    e_rsp = 1'b0;
    e_err = 1'b0;
    if (r) begin
      sweep_left = DP;
      e_data = '0;
      chk_en = 1'b1;
    end else if (!was_ready) begin
      mm[DP - sweep_left] = '0;
      sweep_left--;
    end else if (v) begin
      if (int'(a) < DP) begin
        if (w) mm[a[3:0]] = d;
        else begin e_rsp = 1'b1; e_data = mm[a[3:0]]; end
      end else begin
        e_err = 1'b1;
        if (!w) begin e_rsp = 1'b1; e_data = '0; end
      end
    end
    e_rdy = (sweep_left == 0);
    @(negedge clk);
  endtask

  // Every-cycle comparison against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("init_done", 32'(init_done), 32'(e_rdy));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_rsp));
      chk("err_out",   32'(err_out),   32'(e_err));
      chk("data_out",  32'(data_out),  32'(e_data));
    end
  end

  task automatic idle();
    cycle(1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  // Holds req_valid with random writes during the sweep; returns edges until ready
  task automatic count_sweep(output int edges);
    edges = 0;
    for (int k = 0; k < 40 && !req_ready; k++) begin
      cycle(1'b0, 1'b1, 1'b1, AW'($urandom_range(0, 15)), DW'($urandom));
      edges++;
    end
  endtask

  initial begin
    int edges;
    for (int i = 0; i < DP; i++) mm[i] = DW'($urandom);

    // Reset and clear sweep
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    count_sweep(edges);
    chk("sweep_latency", 32'(edges), 32'd16);
    for (int i = 0; i < DP; i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), '0);
      chk("clear_read", 32'(data_out), 32'h00);
    end

    // Write then read back-to-back
    cycle(1'b0, 1'b1, 1'b1, 8'h03, 8'hA5);
    chk("wr_no_rsp", 32'(rsp_valid), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h03, '0);
    chk("rd_rsp", 32'(rsp_valid), 32'd1);
    chk("rd_data", 32'(data_out), 32'hA5);
    chk("model_pin_a5", 32'(e_data), 32'hA5);

    // Streaming
    for (int i = 0; i < 8; i++) cycle(1'b0, 1'b1, 1'b1, AW'(i), DW'(8'h10 + i));
    for (int i = 0; i < 8; i++) begin
      cycle(1'b0, 1'b1, 1'b0, AW'(i), '0);
      chk("stream_vld", 32'(rsp_valid), 32'd1);
      chk("stream_data", 32'(data_out), 32'(8'h10 + i));
    end
    idle();
    chk("stream_hold", 32'(data_out), 32'h17);
    chk("stream_idle", 32'(rsp_valid), 32'd0);

    // Out of range
    cycle(1'b0, 1'b1, 1'b1, 8'h20, 8'hFF);
    chk("oor_wr_err", 32'(err_out), 32'd1);
    chk("oor_wr_rsp", 32'(rsp_valid), 32'd0);
    idle();
    chk("oor_err_pulse", 32'(err_out), 32'd0);
    cycle(1'b0, 1'b1, 1'b0, 8'h20, '0);
    chk("oor_rd_rsp", 32'(rsp_valid), 32'd1);
    chk("oor_rd_data", 32'(data_out), 32'h00);
    chk("oor_rd_err", 32'(err_out), 32'd1);
    for (int i = 0; i < DP; i++) cycle(1'b0, 1'b1, 1'b0, AW'(i), '0);

    // Reset mid-sweep restarts the full sweep
    cycle(1'b1, 1'b0, 1'b0, '0, '0);
    for (int i = 0; i < 7; i++) idle();
    cycle(1'b1, 1'b1, 1'b1, 8'h01, 8'h77);
    count_sweep(edges);
    chk("midsweep_latency", 32'(edges), 32'd16);

    // Reset wins over a simultaneous write
    cycle(1'b0, 1'b1, 1'b1, 8'h02, 8'h33);
    cycle(1'b1, 1'b1, 1'b1, 8'h02, 8'h5A);
    count_sweep(edges);
    chk("rst_wr_latency", 32'(edges), 32'd16);
    cycle(1'b0, 1'b1, 1'b0, 8'h02, '0);
    chk("rst_wr_data", 32'(data_out), 32'h00);

    // Randomised traffic, including out-of-range addresses and idle cycles
    for (int i = 0; i < 600; i++) begin
      cycle(1'b0, 1'($urandom_range(0, 3) != 0), 1'($urandom),
            AW'(($urandom_range(0, 9) == 0) ? $urandom_range(16, 255) : $urandom_range(0, 15)),
            DW'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
